gate_test_sequencer: RTL

//   Self-test controller for the 2-input basic-gate cells (AND/OR/NAND/NOR/XOR/XNOR).
//   On start, drives all four {A,B} vectors into one gate under test (GUT) and waits a settle time.
//   It then samples Y against the truth table of the selected gate type.

---
 rtl/gate_test_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gate_test_sequencer.sv
// Self-test sequencer for 2-input basic-gate cells. It drives the four {a,b}
// vectors into the gate under test and waits a settle time on each one. It then
// checks Y against the truth table of the selected gate and reports pass/fail,
// a per-vector fail mask and a saturating error count.
module gate_test_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             cfg_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_mask
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [7:0]       SETTLE_LD = 8'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             dut_a_q, dut_a_d, dut_b_q, dut_b_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       fail_mask_q, fail_mask_d;
  logic             pass_q, pass_d, cfg_err_q, cfg_err_d;
  logic             exp_y;
  logic [1:0]       vec_nxt;

  // Expected Y of the latched gate type for the vector currently driven.
  always_comb begin
    exp_y = 1'b0;
    case (sel_q)
      3'b000:  exp_y = dut_a_q & dut_b_q;
      3'b001:  exp_y = dut_a_q | dut_b_q;
      3'b010:  exp_y = ~(dut_a_q & dut_b_q);
      3'b011:  exp_y = ~(dut_a_q | dut_b_q);
      3'b100:  exp_y = dut_a_q ^ dut_b_q;
      3'b101:  exp_y = ~(dut_a_q ^ dut_b_q);
      default: exp_y = 1'b0;
    endcase
  end

  // Next-state and datapath updates for the run sequencer.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    dut_a_d     = dut_a_q;
    dut_b_d     = dut_b_q;
    err_cnt_d   = err_cnt_q;
    fail_mask_d = fail_mask_q;
    pass_d      = pass_q;
    cfg_err_d   = cfg_err_q;
    vec_nxt     = vec_q + 2'd1;
    case (state_q)
      IDLE: begin
        dut_a_d = 1'b0;
        dut_b_d = 1'b0;
        if (start) begin
          sel_d       = gate_sel;
          err_cnt_d   = '0;
          fail_mask_d = '0;
          pass_d      = 1'b0;
          cfg_err_d   = 1'b0;
          if (gate_sel[2:1] == 2'b11) begin
            cfg_err_d = 1'b1;
            state_d   = DONE;
          end else begin
            vec_d   = 2'd0;
            cnt_d   = SETTLE_LD;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        // Counter loaded with SETTLE_CYCLES; leave on the edge it reads 1.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = CHECK;
      end
      CHECK: begin
        if (dut_y != exp_y) begin
          fail_mask_d[vec_q] = 1'b1;
          if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_ONE;
        end
        if (vec_q == 2'd3) begin
          dut_a_d = 1'b0;
          dut_b_d = 1'b0;
          state_d = DONE;
        end else begin
          vec_d   = vec_nxt;
          dut_a_d = vec_nxt[1];
          dut_b_d = vec_nxt[0];
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end
      end
      DONE: begin
        pass_d  = (err_cnt_q == '0) && !cfg_err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; async reset discards any run in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= 2'd0;
      cnt_q       <= 8'd0;
      sel_q       <= 3'd0;
      dut_a_q     <= 1'b0;
      dut_b_q     <= 1'b0;
      err_cnt_q   <= '0;
      fail_mask_q <= 4'd0;
      pass_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
      err_cnt_q   <= err_cnt_d;
      fail_mask_q <= fail_mask_d;
      pass_q      <= pass_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign cfg_err   = cfg_err_q;
  assign err_cnt   = err_cnt_q;
  assign fail_mask = fail_mask_q;

endmodule
